// File: rtl/arc4_prga.sv
// ARC4 keystream generator and decrypt stage: walks the pre-scheduled S-box,
// XORs the keystream with a length-prefixed ciphertext and writes the plaintext.
module arc4_prga (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_LEN,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_S6,
    ST_S7
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_cbyte;

  logic [7:0] w_i_inc;
  logic [7:0] w_j_sum;
  logic [7:0] w_pad_addr;

  assign w_i_inc    = r_i + 8'd1;
  assign w_j_sum    = r_j + s_rddata;
  assign w_pad_addr = r_si + r_sj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_next = ST_START;
      ST_START: w_state_next = ST_LEN;
      ST_LEN:   w_state_next = (ct_rddata == 8'd0) ? ST_IDLE : ST_S1;
      ST_S1:    w_state_next = ST_S2;
      ST_S2:    w_state_next = ST_S3;
      ST_S3:    w_state_next = ST_S4;
      ST_S4:    w_state_next = ST_S5;
      ST_S5:    w_state_next = ST_S6;
      ST_S6:    w_state_next = ST_S7;
      ST_S7:    w_state_next = (r_k == r_len) ? ST_IDLE : ST_S1;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers; read data arrives one cycle after its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= 8'd0;
      r_len   <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_cbyte <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_i <= 8'd0;
            r_j <= 8'd0;
            r_k <= 8'd1;
          end
        end
        ST_LEN: r_len <= ct_rddata;
        ST_S1:  r_i <= w_i_inc;
        ST_S2: begin
          r_si    <= s_rddata;
          r_cbyte <= ct_rddata;
          r_j     <= w_j_sum;
        end
        ST_S3:  r_sj <= s_rddata;
        ST_S7:  if (r_k != r_len) r_k <= r_k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy       = (r_state == ST_IDLE);
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (r_state)
      ST_LEN: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      ST_S1: begin
        s_addr  = w_i_inc;
        ct_addr = r_k;
      end
      ST_S2: s_addr = w_j_sum;
      // When i == j both swap writes land on one address with the same value.
      ST_S4: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = 1'b1;
      end
      ST_S5: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
      end
      ST_S6: s_addr = w_pad_addr;
      ST_S7: begin
        pt_addr   = r_k;
        pt_wrdata = s_rddata ^ r_cbyte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- Pseudo-random generation and decrypt stage of the ARC4 decryption circuit.
- Sits downstream of the init/KSA stages.
  - Reads the key-scheduled S-box from S memory, already filled by KSA.
  - Reads a length-prefixed ciphertext from CT memory.
  - Writes the length-prefixed plaintext to PT memory.
- Consumer/reader end of the S memory that KSA writes; uses the same en/rdy handshake as KSA.

Parameters:
- None. All widths are fixed by ARC4: 8-bit data, 8-bit addresses, 256-entry memories.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  start request; honoured only while rdy=1
rdy  output  1  1 = idle and ready to accept en
s_addr  output  8  S memory address
s_rddata  input  8  S memory read data; valid the cycle after its address
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable
ct_addr  output  8  CT memory address (read-only)
ct_rddata  input  8  CT read data; 1-cycle latency
pt_addr  output  8  PT memory address
pt_wrdata  output  8  PT write data
pt_wren  output  1  PT write enable

Behaviour:
- Memory model: synchronous single-port RAMs. Address driven in cycle c gives data on *_rddata in cycle c+1. A write takes effect at the edge that ends the wren cycle.
- Reset (asynchronous, any time, including mid-message):
  - State returns to IDLE; in-flight work is abandoned.
  - rdy=1; s_wren=0; pt_wren=0; all addresses and write data 0.
  - Internal i, j, k, L, si, sj, cbyte all 0.
- Handshake:
  - en is sampled at an edge while rdy=1; that edge is E0. rdy drops after E0.
  - en is ignored while busy.
  - rdy rises again after edge E0+2+7L; L is the message length.
  - en held high while rdy=1 restarts immediately.
- Message format:
  - ct[0]=L (0..255); ct[1..L] are the ciphertext bytes.
  - PT gets pt[0]=L and pt[k]=ct[k] XOR pad_k.
- All index and sum arithmetic is 8-bit modulo 256; carries are dropped.
- States, per cycle:
  - IDLE: rdy=1. On en: i←0, j←0, k←1 → START.
  - START: ct_addr=0 → LEN.
  - LEN: L←ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1. If ct_rddata==0 → IDLE, else → S1.
  - S1: s_addr=i+1; i←i+1; ct_addr=k → S2.
  - S2: si←s_rddata; cbyte←ct_rddata; s_addr=j+s_rddata; j←j+s_rddata → S3.
  - S3: sj←s_rddata → S4.
  - S4: s_addr=i, s_wrdata=sj, s_wren=1 → S5.
  - S5: s_addr=j, s_wrdata=si, s_wren=1 → S6.
  - S6: s_addr=si+sj → S7.
  - S7: pt_addr=k, pt_wrdata=s_rddata XOR cbyte, pt_wren=1. If k==L → IDLE, else k←k+1 → S1.
- Exactly 7 cycles per byte.
- i==j: both S writes hit the same address with the same value. Result is correct swap semantics; no special case.
- L=255: k reaches 255 and compares equal to L; there is no wrap past it.
- At most one of s_wren and pt_wren is high in any cycle. Enables are high only in S4, S5 (s_wren) and LEN, S7 (pt_wren).
- S is left in its post-PRGA permuted state. Re-running requires KSA to be rerun first.

Test Plan:
- Identity S (S[x]=x), ct={02,00,00} → pt={02,02,05}; final S[2]=03, S[3]=02; rdy rises after E0+16.
- S from KSA with key 0x4B6579, ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} → pt={09,50,6C,61,69,6E,74,65,78,74} ("Plaintext"); rdy after E0+65.
- ct[0]=00 → exactly one PT write (addr 0, data 00); no S writes; rdy after E0+2.
- Pulse rst during the 4th byte → rdy=1 and both wrens low in the same cycle. Reload S, then restart → correct full plaintext.
- en held high continuously → second run starts the cycle rdy reasserts. en pulsed while busy → no effect on timing or PT contents.
- L=255 with identity S and all-zero CT → 256 PT writes; pt[k] matches the software ARC4 model; no write to address 0 after LEN.
